// File: rtl/clb_config_loader.sv
// CLB configuration loader.
// Accepts CFG_BYTES bytes over a valid/ready byte port, shifts each one into
// the CLB chain MSB first, then pulses cfg_latch once to commit the chain.
module clb_config_loader #(
  parameter int CFG_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_bit,
  output logic       cfg_shift,
  output logic       cfg_latch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2,
    LATCH     = 2'd3
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(CFG_BYTES - 1);

  state_t     state_q, state_d;
  logic [7:0] sreg_q, sreg_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       done_q, done_d;

  // Next-state and datapath update; abort outranks every other event.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    done_d     = done_q;
    if (abort) begin
      // Partial chain is left unlatched; a LATCH pulse already on the wire
      // still completes but never reports done.
      state_d    = IDLE;
      sreg_d     = 8'd0;
      byte_cnt_d = 8'd0;
      bit_cnt_d  = 3'd0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = WAIT_BYTE;
            done_d     = 1'b0;
            byte_cnt_d = 8'd0;
          end
        end
        WAIT_BYTE: begin
          if (in_valid) begin
            sreg_d    = in_data;
            bit_cnt_d = 3'd0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          sreg_d = {sreg_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == LAST_BYTE) begin
              state_d = LATCH;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
              state_d    = WAIT_BYTE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        LATCH: begin
          state_d    = IDLE;
          done_d     = 1'b1;
          byte_cnt_d = 8'd0;
          bit_cnt_d  = 3'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= 8'd0;
      byte_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      done_q     <= done_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    in_ready  = (state_q == WAIT_BYTE);
    cfg_shift = (state_q == SHIFT);
    cfg_bit   = (state_q == SHIFT) & sreg_q[7];
    cfg_latch = (state_q == LATCH);
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule
